// File: rtl/sqm_pkg.sv
// Shared types and default sizes for the square-and-multiply modular exponentiator.
package sqm_pkg;

    localparam int unsigned SQM_WIDTH     = 8;
    localparam int unsigned SQM_EXP_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } sqm_state_e;

endpackage : sqm_pkg

// File: rtl/sqm_modmul.sv
// Combinational modular multiply: p_c = (a*b) mod m, full-width product, 0 when m==0.
module sqm_modmul
    import sqm_pkg::*;
#(
    parameter int unsigned WIDTH = SQM_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] p_c
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0] prod;
    logic [PW-1:0] rem;

    // Double-width product reduced without truncation; zero modulus yields 0.
    always_comb begin
        prod = PW'(a) * PW'(b);
        rem  = '0;
        if (m != '0) begin
            rem = prod % PW'(m);
        end
        p_c = WIDTH'(rem);
    end

endmodule : sqm_modmul

// File: rtl/sqm_exp.sv
// Left-to-right square-and-multiply modular exponentiator: result = base^exp mod modulus.
// Optional macro SQM_EXP_CONST_TIME_EN makes every exponent bit cost one SQ plus one MUL.
module sqm_exp
    import sqm_pkg::*;
#(
    parameter int unsigned WIDTH     = SQM_WIDTH,
    parameter int unsigned EXP_WIDTH = SQM_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exp,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 err
);

    localparam int unsigned IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    sqm_state_e           state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     base_q, base_d;
    logic [WIDTH-1:0]     mod_q, mod_d;
    logic [EXP_WIDTH-1:0] exp_q, exp_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [WIDTH-1:0]     result_d;
    logic                 err_d;
    logic                 out_valid_d;
    logic                 in_ready_d;

    logic [WIDTH-1:0]     op_a, op_b, op_m;
    logic [WIDTH-1:0]     mm_p;
    logic [WIDTH-1:0]     mul_val;

    // Single shared multiplier: base reduction in IDLE, acc*acc in SQ, acc*base in MUL.
    sqm_modmul #(
        .WIDTH (WIDTH)
    ) u_modmul (
        .a   (op_a),
        .b   (op_b),
        .m   (op_m),
        .p_c (mm_p)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            base_q    <= '0;
            mod_q     <= '0;
            exp_q     <= '0;
            idx_q     <= '0;
            result    <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            base_q    <= base_d;
            mod_q     <= mod_d;
            exp_q     <= exp_d;
            idx_q     <= idx_d;
            result    <= result_d;
            err       <= err_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
        end
    end

    // Next-state, operand selection and register updates.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        mod_d    = mod_q;
        exp_d    = exp_q;
        idx_d    = idx_q;
        result_d = result;
        err_d    = err;
        op_a     = acc_q;
        op_b     = acc_q;
        op_m     = mod_q;
        mul_val  = mm_p;

        unique case (state_q)
            IDLE: begin
                op_a = base;
                op_b = WIDTH'(1);
                op_m = modulus;
                if (in_valid && in_ready) begin
                    exp_d  = exp;
                    mod_d  = modulus;
                    base_d = mm_p;
                    idx_d  = IW'(EXP_WIDTH - 1);
                    if (modulus == '0) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        err_d   = 1'b0;
                        acc_d   = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                        state_d = SQ;
                    end
                end
            end

            SQ: begin
                acc_d = mm_p;
`ifdef SQM_EXP_CONST_TIME_EN
                state_d = MUL;
`else
                if (exp_q[idx_q]) begin
                    state_d = MUL;
                end else if (idx_q == '0) begin
                    result_d = mm_p;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
`endif
            end

            MUL: begin
                op_b = base_q;
`ifdef SQM_EXP_CONST_TIME_EN
                // Multiply always runs; its product is kept only for set exponent bits.
                mul_val = exp_q[idx_q] ? mm_p : acc_q;
`endif
                acc_d = mul_val;
                if (idx_q == '0) begin
                    result_d = mul_val;
                    state_d  = DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = SQ;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

endmodule : sqm_exp

// File: tb/tb_sqm_exp.sv
// Directed self-checking bench for sqm_exp (WIDTH=8, EXP_WIDTH=4).
module tb_sqm_exp;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] base;
    logic [3:0] exp;
    logic [7:0] modulus;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       err;

    int errors = 0;
    int checks = 0;

    sqm_exp #(
        .WIDTH     (8),
        .EXP_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .base      (base),
        .exp       (exp),
        .modulus   (modulus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for out_valid; lat counts edges from the accept edge.
    task automatic issue(input logic [7:0] b, input logic [3:0] e, input logic [7:0] m,
                         output int lat);
        int wait_cnt;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 40) begin
            tick();
            wait_cnt++;
        end
        in_valid = 1'b1;
        base     = b;
        exp      = e;
        modulus  = m;
        tick();
        in_valid = 1'b0;
        base     = 8'hA5;
        exp      = 4'h9;
        modulus  = 8'h00;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Run one request with out_ready high and check result, err and latency.
    task automatic run_vec(input string name, input logic [7:0] b, input logic [3:0] e,
                           input logic [7:0] m, input logic [7:0] exp_res,
                           input logic exp_err, input int exp_lat);
        int lat;
        out_ready = 1'b1;
        issue(b, e, m, lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (result !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %0d expected %0d", name, result, exp_res);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s err: got %0b expected %0b", name, err, exp_err);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        base      = '0;
        exp       = '0;
        modulus   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset out_valid: got %0b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset in_ready: got %0b expected 1", in_ready);
        end
        checks++;
        if (result !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset result/err: got %0d/%0b expected 0/0", result, err);
        end
    endtask

    task automatic test_basic();
`ifdef SQM_EXP_CONST_TIME_EN
        run_vec("b3e13m17", 8'd3, 4'd13, 8'd17, 8'd12, 1'b0, 9);
`else
        run_vec("b3e13m17", 8'd3, 4'd13, 8'd17, 8'd12, 1'b0, 8);
`endif
    endtask

    task automatic test_base_gt_mod();
        // 20 mod 7 = 6, 6*6 = 36 mod 7 = 1
`ifdef SQM_EXP_CONST_TIME_EN
        run_vec("b20e2m7", 8'd20, 4'd2, 8'd7, 8'd1, 1'b0, 9);
`else
        run_vec("b20e2m7", 8'd20, 4'd2, 8'd7, 8'd1, 1'b0, 6);
`endif
    endtask

    task automatic test_exp_zero();
`ifdef SQM_EXP_CONST_TIME_EN
        run_vec("b5e0m7", 8'd5, 4'd0, 8'd7, 8'd1, 1'b0, 9);
`else
        run_vec("b5e0m7", 8'd5, 4'd0, 8'd7, 8'd1, 1'b0, 5);
`endif
    endtask

    task automatic test_mod_edges();
        run_vec("mod0", 8'd9, 4'd5, 8'd0, 8'd0, 1'b1, 1);
`ifdef SQM_EXP_CONST_TIME_EN
        run_vec("mod1", 8'd9, 4'd5, 8'd1, 8'd0, 1'b0, 9);
`else
        run_vec("mod1", 8'd9, 4'd5, 8'd1, 8'd0, 1'b0, 7);
`endif
    endtask

    task automatic test_hold();
        int lat;
        out_ready = 1'b0;
        // 2^3 mod 5 = 3
        issue(8'd2, 4'd3, 8'd5, lat);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 8'd3 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: out_valid=%0b result=%0d in_ready=%0b expected 1/3/0",
                         i, out_valid, result, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold release: out_valid=%0b in_ready=%0b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        base      = 8'd3;
        exp       = 4'd13;
        modulus   = 8'd17;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid state: out_valid=%0b in_ready=%0b expected 0/1", out_valid, in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid stale out_valid: got 1 expected 0");
        end
        // 2^15 = 32768 = 130*251 + 138
        run_vec("b2e15m251", 8'd2, 4'd15, 8'd251, 8'd138, 1'b0, 9);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_base_gt_mod();
        test_exp_zero();
        test_mod_edges();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sqm_exp
